// File: rtl/cos_sched_pkg.sv
// Shared defaults, FSM state encoding and address arithmetic helpers for cos_lut_scheduler.
package cos_sched_pkg;

  localparam int COS_ADDR_W    = 11;
  localparam int COS_DATA_W    = 15;
  localparam int COS_TABLE_LEN = 2001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_I = 3'd1,
    CAP_I  = 3'd2,
    WAIT_Q = 3'd3,
    CAP_Q  = 3'd4
  } state_e;

  // Single subtraction suffices: both operands of every sum are below len.
  function automatic logic [31:0] wrap(input logic [31:0] x, input logic [31:0] len);
    return (x >= len) ? (x - len) : x;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] x, input logic [31:0] maxv);
    return (x > maxv) ? maxv : x;
  endfunction

endpackage

// File: rtl/cos_tick_div.sv
// Programmable sample-tick divider: one tick every div_cfg+1 enabled cycles.
module cos_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= so that lowering div_cfg below the running count fires at once
  assign tick = enable && (cnt_q >= div_cfg);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!enable || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cos_lut_scheduler.sv
// Time-shares one cosine ROM between I and Q reads per sample tick.
// Define COS_SCHED_IQ_EN for the full I/Q sequence; otherwise I-only with q_out tied to 0.
module cos_lut_scheduler #(
  parameter int ADDR_W     = cos_sched_pkg::COS_ADDR_W,
  parameter int DATA_W     = cos_sched_pkg::COS_DATA_W,
  parameter int TABLE_LEN  = cos_sched_pkg::COS_TABLE_LEN,
  parameter int DIV_W      = 16,
  parameter int ROM_LAT    = 1,
  parameter int PHASE_INIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] q_offset,
  input  logic              phase_clr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] i_out,
  output logic [DATA_W-1:0] q_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);
  import cos_sched_pkg::*;

  localparam int WCNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(ROM_LAT - 1);

  state_e            state_q, state_d;
  logic              tick;
  logic [ADDR_W-1:0] phase_q, step_q, rom_addr_q, ph_next;
  logic [ADDR_W:0]   ph_sum;
  logic [WCNT_W-1:0] wcnt_q;
  logic              wait_done, clr_pend_q, ovr_q, sv_q;
  logic [DATA_W-1:0] i_out_q;

  cos_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .div_cfg (div_cfg),
    .tick    (tick)
  );

  assign wait_done = (wcnt_q == WLAST);
  assign ph_sum    = {1'b0, phase_q} + {1'b0, step_q};
  // A clear arriving on the completing edge itself still wins over the advance
  assign ph_next   = (clr_pend_q || phase_clr) ? '0
                   : ADDR_W'(wrap(32'(ph_sum), TABLE_LEN));

`ifdef COS_SCHED_IQ_EN
  logic [ADDR_W-1:0] qoff_q, q_addr;
  logic [ADDR_W:0]   q_sum;
  logic [DATA_W-1:0] i_hold_q, q_out_q;
  assign q_sum  = {1'b0, phase_q} + {1'b0, qoff_q};
  assign q_addr = ADDR_W'(wrap(32'(q_sum), TABLE_LEN));
  assign q_out  = q_out_q;
`else
  logic unused_qoff;
  assign unused_qoff = ^q_offset;
  assign q_out       = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = WAIT_I;
      WAIT_I:  if (wait_done) state_d = CAP_I;
`ifdef COS_SCHED_IQ_EN
      CAP_I:   state_d = WAIT_Q;
      WAIT_Q:  if (wait_done) state_d = CAP_Q;
      CAP_Q:   state_d = IDLE;
`else
      CAP_I:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= ADDR_W'(PHASE_INIT);
      step_q     <= '0;
      rom_addr_q <= '0;
      wcnt_q     <= '0;
      clr_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
      sv_q       <= 1'b0;
      i_out_q    <= '0;
`ifdef COS_SCHED_IQ_EN
      qoff_q     <= '0;
      i_hold_q   <= '0;
      q_out_q    <= '0;
`endif
    end else begin
      sv_q <= 1'b0;
      if (!enable)                        ovr_q <= 1'b0;
      else if (tick && state_q != IDLE)   ovr_q <= 1'b1;
      if (phase_clr && state_q != IDLE)   clr_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (phase_clr) phase_q <= '0;
          if (tick) begin
            rom_addr_q <= phase_clr ? '0 : phase_q;
            step_q     <= ADDR_W'(sat(32'(step), TABLE_LEN - 1));
`ifdef COS_SCHED_IQ_EN
            qoff_q     <= ADDR_W'(sat(32'(q_offset), TABLE_LEN - 1));
`endif
            wcnt_q     <= '0;
          end
        end
        WAIT_I, WAIT_Q: wcnt_q <= wait_done ? '0 : wcnt_q + WCNT_W'(1);
`ifdef COS_SCHED_IQ_EN
        CAP_I: begin
          i_hold_q   <= rom_q;
          rom_addr_q <= q_addr;
        end
        CAP_Q: begin
          i_out_q    <= i_hold_q;
          q_out_q    <= rom_q;
          sv_q       <= 1'b1;
          phase_q    <= ph_next;
          clr_pend_q <= 1'b0;
        end
`else
        CAP_I: begin
          i_out_q    <= rom_q;
          sv_q       <= 1'b1;
          phase_q    <= ph_next;
          clr_pend_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign rom_addr     = rom_addr_q;
  assign i_out        = i_out_q;
  assign sample_valid = sv_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = ovr_q;

endmodule
